relu_seq_ctrl: RTL and testbench

Sequencer that streams one feature-map tile through the ReLU activation unit. It reads `len` words from an on-chip source buffer, drives the ReLU unit's `enable` exactly on cycles that carry valid data, and writes the activated results to a destination buffer. It sits between the accelerator's layer controller, which issues start and receives done, and the ReLU datapath with its two buffer ports. The controller does not touch data: buffer read data feeds ReLU `x`, and ReLU `out` feeds buffer write data directly.

---
 rtl/relu_seq_ctrl_if.sv | 45 ++++
 rtl/relu_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_relu_seq_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/relu_seq_ctrl_if.sv
// relu_seq_ctrl_if: bundles the layer-controller request/status signals and the
// buffer/ReLU strobes of relu_seq_ctrl. The master modport is the side that
// issues jobs and observes the strobes; the slave modport is the sequencer.
// Optional macro RELU_SEQ_CTRL_PERF_EN adds the perf_cycles counter output.
interface relu_seq_ctrl_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
);
    // Job request from the layer controller
    logic                  start;
    logic [ADDR_WIDTH-1:0] src_base;
    logic [ADDR_WIDTH-1:0] dst_base;
    logic [LEN_WIDTH-1:0]  len;
    logic                  hold;
    // Status back to the layer controller
    logic                  busy;
    logic                  done;
    // Source buffer read port, ReLU enable, destination buffer write port
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  relu_enable;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    // Current FSM state, for debug and checkers
    logic [1:0]            state_dbg;
`ifdef RELU_SEQ_CTRL_PERF_EN
    logic [31:0]           perf_cycles;
`endif

    modport master (
`ifdef RELU_SEQ_CTRL_PERF_EN
        input  perf_cycles,
`endif
        output start, src_base, dst_base, len, hold,
        input  busy, done, rd_en, rd_addr, relu_enable, wr_en, wr_addr, state_dbg
    );

    modport slave (
`ifdef RELU_SEQ_CTRL_PERF_EN
        output perf_cycles,
`endif
        input  start, src_base, dst_base, len, hold,
        output busy, done, rd_en, rd_addr, relu_enable, wr_en, wr_addr, state_dbg
    );
endinterface

// File: rtl/relu_seq_ctrl.sv
// relu_seq_ctrl: streams one tile from the source buffer through the ReLU unit
// into the destination buffer. Reads are issued from ISSUE, buffer data is valid
// one cycle later (ReLU enable), the registered ReLU result is written one cycle
// after that. The destination address rides with the valid bits so hold bubbles
// never misalign writes.
// Optional macro RELU_SEQ_CTRL_PERF_EN adds a 32-bit busy-cycle counter.
//
// Handshake: start is a request without a ready; it is taken only in a cycle
// where busy is low (IDLE), together with src_base/dst_base/len, and is ignored
// otherwise. done pulses for exactly one cycle when the job has fully drained,
// and busy stays high from the cycle after acceptance through the done cycle.
module relu_seq_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input logic           clk,
    input logic           rst,
    relu_seq_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    logic [1:0]            state_q, state_d;
    logic [LEN_WIDTH-1:0]  i_q, i_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    // Stage 1: buffer data valid this cycle (ReLU enable)
    logic                  v1_q, v1_d;
    logic [ADDR_WIDTH-1:0] a1_q, a1_d;
    // Stage 2: ReLU output registered, write this cycle
    logic                  v2_q, v2_d;
    logic [ADDR_WIDTH-1:0] a2_q, a2_d;

    logic                  rd_en_c;
    logic [ADDR_WIDTH-1:0] rd_addr_c;

    // Next-state, issue and pipeline-advance logic
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        len_d     = len_q;
        src_d     = src_q;
        dst_d     = dst_q;
        v1_d      = 1'b0;
        a1_d      = a1_q;
        v2_d      = v1_q;
        a2_d      = a1_q;
        rd_en_c   = 1'b0;
        rd_addr_c = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        src_d   = bus.src_base;
                        dst_d   = bus.dst_base;
                        len_d   = bus.len;
                        i_d     = '0;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (!bus.hold) begin
                    rd_en_c   = 1'b1;
                    rd_addr_c = src_q + i_q[ADDR_WIDTH-1:0];
                    v1_d      = 1'b1;
                    a1_d      = dst_q + i_q[ADDR_WIDTH-1:0];
                    i_d       = i_q + LEN_ONE;
                    if (i_q == len_q - LEN_ONE) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // No reads are issued here, so once stage 1 is empty both
                // stages are empty from the next cycle on: DONE starts then.
                if (!v1_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, job parameters and pipeline registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            len_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            v1_q    <= 1'b0;
            a1_q    <= '0;
            v2_q    <= 1'b0;
            a2_q    <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            len_q   <= len_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            v1_q    <= v1_d;
            a1_q    <= a1_d;
            v2_q    <= v2_d;
            a2_q    <= a2_d;
        end
    end

`ifdef RELU_SEQ_CTRL_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Busy-cycle counter: cleared on acceptance, frozen while IDLE
    always_comb begin
        perf_d = perf_q;
        if (state_q == S_IDLE) begin
            if (bus.start) begin
                perf_d = '0;
            end
        end else begin
            perf_d = perf_q + 32'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign bus.perf_cycles = perf_q;
`endif

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.rd_en       = rd_en_c;
    assign bus.rd_addr     = rd_addr_c;
    assign bus.relu_enable = v1_q;
    assign bus.wr_en       = v2_q;
    assign bus.wr_addr     = v2_q ? a2_q : '0;
    assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_relu_seq_ctrl.sv
// tb_relu_seq_ctrl: directed and randomized jobs for relu_seq_ctrl. A reference
// schedule is derived per job from the hold pattern (issue cycles, then +1/+2
// offsets), and a buffer/ReLU stand-in feeds a write scoreboard.
// Optional macro RELU_SEQ_CTRL_PERF_EN enables perf_cycles checks.
module tb_relu_seq_ctrl;
    localparam int AW   = 12;
    localparam int LW   = 13;
    localparam int DW   = 8;
    localparam int MAXC = 8400;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    relu_seq_ctrl_if #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();
    relu_seq_ctrl #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- buffer + ReLU stand-in ----------------
    logic [DW-1:0] src_mem [0:(1<<AW)-1];
    logic [DW-1:0] rd_data;
    logic [DW-1:0] relu_out;
    always @(posedge clk) if (bus.rd_en) rd_data <= src_mem[bus.rd_addr];
    always @(posedge clk) if (bus.relu_enable) relu_out <= rd_data[DW-1] ? '0 : rd_data;

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [AW+DW-1:0] exp_q[$];
    bit               hold_pat [0:MAXC-1];
    bit               busy_e   [0:MAXC-1];
    bit               done_e   [0:MAXC-1];
    bit               rd_e     [0:MAXC-1];
    bit               relu_e   [0:MAXC-1];
    bit               wr_e     [0:MAXC-1];
    logic [AW-1:0]    rda_e    [0:MAXC-1];
    logic [AW-1:0]    wra_e    [0:MAXC-1];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] relu_ref(input logic [DW-1:0] x);
        return ($signed(x) < 0) ? '0 : x;
    endfunction

    task automatic set_hold(input int pct);
        for (int c = 0; c < MAXC; c++) hold_pat[c] = ($urandom_range(0, 99) < pct);
    endtask

    // ---------------- driver + model ----------------
    // rst_cyc > 0: assert rst during that cycle. ign_cyc > 0: pulse start then.
    task automatic run_job(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                           input int n, input int rst_cyc, input int ign_cyc);
        int issue[$];
        int c;
        int done_c;
        int last_c;
        logic [AW+DW-1:0] e;
        logic [28:0] obs_v;
        logic [28:0] exp_v;

        // Reference schedule: the k-th read goes out on the k-th non-hold cycle
        c = 1;
        while (issue.size() < n && c < MAXC - 8) begin
            if (!hold_pat[c]) issue.push_back(c);
            c++;
        end
        done_c = (n == 0) ? 1 : issue[n-1] + 3;
        last_c = (rst_cyc > 0) ? rst_cyc + 8 : done_c + 1;
        for (int j = 0; j < MAXC; j++) begin
            busy_e[j] = 0; done_e[j] = 0; rd_e[j] = 0; relu_e[j] = 0; wr_e[j] = 0;
            rda_e[j] = '0; wra_e[j] = '0;
        end
        for (int j = 1; j <= done_c; j++) busy_e[j] = 1;
        done_e[done_c] = 1;
        for (int k = 0; k < n; k++) begin
            rd_e[issue[k]]       = 1;
            rda_e[issue[k]]      = src + AW'(k);
            relu_e[issue[k] + 1] = 1;
            wr_e[issue[k] + 2]   = 1;
            wra_e[issue[k] + 2]  = dst + AW'(k);
            if (rst_cyc == 0 || issue[k] + 2 <= rst_cyc)
                exp_q.push_back({dst + AW'(k), relu_ref(src_mem[src + AW'(k)])});
        end
        if (rst_cyc > 0) begin
            for (int j = rst_cyc + 1; j < MAXC; j++) begin
                busy_e[j] = 0; done_e[j] = 0; rd_e[j] = 0; relu_e[j] = 0; wr_e[j] = 0;
                rda_e[j] = '0; wra_e[j] = '0;
            end
        end

        // Cycle 0: request is presented and sampled at the next edge
        bus.src_base = src;
        bus.dst_base = dst;
        bus.len      = LW'(n);
        bus.start    = 1'b1;
        bus.hold     = hold_pat[0];
        @(posedge clk);
        for (int cc = 1; cc <= last_c; cc++) begin
            #1;
            bus.start = (cc == ign_cyc);
            if (cc == ign_cyc) begin
                bus.src_base = AW'($urandom);
                bus.dst_base = AW'($urandom);
                bus.len      = LW'($urandom_range(1, 30));
            end
            bus.hold = hold_pat[cc];
            rst      = (cc == rst_cyc);
            @(negedge clk);
            obs_v = {bus.busy, bus.done, bus.rd_en, bus.rd_addr, bus.relu_enable, bus.wr_en, bus.wr_addr};
            exp_v = {busy_e[cc], done_e[cc], rd_e[cc], rda_e[cc], relu_e[cc], wr_e[cc], wra_e[cc]};
            check($sformatf("outs@c%0d", cc), 64'(obs_v), 64'(exp_v));
            if (bus.wr_en) begin
                check($sformatf("wr_extra@c%0d", cc), 64'(exp_q.size() == 0), 64'(0));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check($sformatf("wr_data@c%0d", cc), 64'({bus.wr_addr, relu_out}), 64'(e));
                end
            end
            if (cc < last_c) @(posedge clk);
        end
        bus.start = 1'b0;
        check("wr_left", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
`ifdef RELU_SEQ_CTRL_PERF_EN
        check("perf", 64'(bus.perf_cycles), 64'((rst_cyc > 0) ? 0 : done_c));
`endif
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.hold     = 1'b0;
        bus.src_base = '0;
        bus.dst_base = '0;
        bus.len      = '0;
        for (int a = 0; a < (1 << AW); a++) src_mem[a] = DW'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs", 64'({bus.busy, bus.done, bus.rd_en, bus.rd_addr,
                                 bus.relu_enable, bus.wr_en, bus.wr_addr}), 64'(0));
`ifdef RELU_SEQ_CTRL_PERF_EN
        check("reset_perf", 64'(bus.perf_cycles), 64'(0));
`endif
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("idle_busy", 64'(bus.busy), 64'(0));

        // Basic tile with mixed-sign data
        src_mem[12'h010] = 8'd5;
        src_mem[12'h011] = 8'hFD;
        src_mem[12'h012] = 8'd0;
        src_mem[12'h013] = 8'hFF;
        set_hold(0);
        run_job(12'h010, 12'h200, 4, 0, 0);

        // Single hold bubble in cycle 2
        set_hold(0);
        hold_pat[2] = 1;
        run_job(12'h040, 12'h300, 3, 0, 0);

        // Zero-length job
        set_hold(0);
        run_job(12'h123, 12'h456, 0, 0, 0);

        // Start while busy is ignored
        run_job(12'h080, 12'h500, 8, 0, 4);

        // Address wrap on both sides
        run_job(12'hFFE, 12'hFFF, 3, 0, 0);

        // Reset mid-job, then a normal job
        run_job(12'h100, 12'h600, 10, 3, 0);
        run_job(12'h020, 12'h700, 2, 0, 0);

        // Random jobs with random hold, including hold during drain/done
        for (int r = 0; r < 8; r++) begin
            set_hold(30);
            run_job(AW'($urandom), AW'($urandom), $urandom_range(1, 40), 0,
                    (r % 3 == 0) ? $urandom_range(2, 6) : 0);
        end

        // Length above 2^ADDR_WIDTH
        set_hold(5);
        run_job(12'h800, 12'hC00, 4099, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
